// File: rtl/dmem_access_unit.sv
// Load/store sequencer between the CPU memory stage and a word-wide data RAM.
// Loads extract and extend a lane; sub-word stores run as read-modify-write.
module dmem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        exc,
  output logic        DM_cs,
  output logic        DM_r,
  output logic        DM_w,
  output logic [10:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [2:0] {IDLE, LD, ST, RMW_RD, RMW_WR} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  size_reg;
  logic        sign_ext_reg;
  logic [12:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merge_reg;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] merged;
  logic [3:0]  lane_en;

  always_comb begin
    misaligned = (size == 2'b11) ||
                 (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00);
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (req && !misaligned) begin
          if (!we)                  state_next = LD;
          else if (size == 2'b10)   state_next = ST;
          else                      state_next = RMW_RD;
        end
      end
      RMW_RD:         state_next = RMW_WR;
      LD, ST, RMW_WR: state_next = IDLE;
      default:        state_next = IDLE;
    endcase

    // RAM strobes depend only on state and latched fields, so they are stable all cycle
    DM_r     = (state_reg == LD) || (state_reg == RMW_RD);
    DM_w     = (state_reg == ST) || (state_reg == RMW_WR);
    DM_cs    = DM_r || DM_w;
    busy     = (state_reg != IDLE);
    dm_addr  = addr_reg[12:2];
    dm_wdata = '0;
    if (state_reg == ST)          dm_wdata = wdata_reg;
    else if (state_reg == RMW_WR) dm_wdata = merged;
  end

  always_comb begin
    ld_byte  = dm_rdata[{addr_reg[1:0], 3'b000} +: 8];
    ld_half  = dm_rdata[{addr_reg[1], 4'b0000} +: 16];
    ld_value = dm_rdata;
    case (size_reg)
      2'b00:   ld_value = {{24{sign_ext_reg & ld_byte[7]}}, ld_byte};
      2'b01:   ld_value = {{16{sign_ext_reg & ld_half[15]}}, ld_half};
      default: ld_value = dm_rdata;
    endcase
  end

  // Per-lane merge: a halfword store covers both lanes of the selected half.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_en[gi] = (size_reg == 2'b00) ? (addr_reg[1:0] == LANE)
                                               : (addr_reg[1] == LANE[1]);
      assign merged[8*gi +: 8] = !lane_en[gi] ? merge_reg[8*gi +: 8] :
                                 ((size_reg == 2'b00) || !LANE[0]) ? wdata_reg[7:0]
                                                                   : wdata_reg[15:8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      size_reg     <= 2'b00;
      sign_ext_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      merge_reg    <= '0;
      rdata        <= '0;
      done         <= 1'b0;
      exc          <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= (state_reg == LD) || (state_reg == ST) || (state_reg == RMW_WR);
      exc       <= (state_reg == IDLE) && req && misaligned;
      if (state_reg == IDLE && req) begin
        size_reg     <= size;
        sign_ext_reg <= sign_ext;
        addr_reg     <= addr[12:0];
        wdata_reg    <= wdata;
      end
      if (state_reg == LD)     rdata     <= ld_value;
      if (state_reg == RMW_RD) merge_reg <= dm_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural word RAM.
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, dm_wdata, dm_rdata;
  logic        done, busy, exc, DM_cs, DM_r, DM_w;
  logic [10:0] dm_addr;

  logic [31:0] mem [0:2047];
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  int checks = 0;
  int errors = 0;

  dmem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .exc(exc),
    .DM_cs(DM_cs), .DM_r(DM_r), .DM_w(DM_w), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (DM_cs && DM_w)  mem[dm_addr] <= dm_wdata;
    else if (pl_en)     mem[pl_addr] <= pl_data;
  end
  assign dm_rdata = (DM_cs && DM_r) ? mem[dm_addr] : 32'hzzzz_zzzz;

  // Strobe exclusivity holds on every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((DM_r && DM_w) || (DM_cs !== (DM_r | DM_w))) begin
        errors++;
        $display("FAIL strobe_excl got cs=%b r=%b w=%b", DM_cs, DM_r, DM_w);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic se,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; size = s; sign_ext = se; addr = a; wdata = d;
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues a load and returns rdata/done observed in T+2
  task automatic do_load(input logic [31:0] a, input logic [1:0] s, input logic se,
                         output logic [31:0] rd, output logic dn);
    drive(1'b1, 1'b0, s, se, a, 32'h0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rd = rdata; dn = done;
    $display("load addr=%h size=%b sext=%b rdata=%h done=%b", a, s, se, rd, dn);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b required 000000", {DM_cs, DM_r, DM_w, busy, done, exc});
    end
    checks++;
    if (rdata !== 32'h0 || dm_addr !== 11'h0 || dm_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h required 0", rdata, dm_addr, dm_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b required 0", busy); end
    $display("reset done");
  endtask

  task automatic test_word;
    logic [31:0] rd; logic dn;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    req = 1'b0;
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b101100 || dm_addr !== 11'd4 || dm_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_t1 got flags=%b addr=%h wdata=%h required 101100 4 deadbeef",
                         {DM_cs, DM_r, DM_w, busy, done, exc}, dm_addr, dm_wdata);
    end
    @(negedge clk);
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b000010 || mem[4] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_t2 got flags=%b mem=%h required 000010 deadbeef",
                         {DM_cs, DM_r, DM_w, busy, done, exc}, mem[4]);
    end
    $display("sw addr=00000010 data=deadbeef");
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    req = 1'b0;
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b110100 || dm_addr !== 11'd4) begin
      errors++; $display("FAIL lw_t1 got flags=%b addr=%h required 110100 4", {DM_cs, DM_r, DM_w, busy, done, exc}, dm_addr);
    end
    @(negedge clk);
    rd = rdata; dn = done;
    checks++;
    if (rd !== 32'hDEADBEEF || dn !== 1'b1) begin
      errors++; $display("FAIL lw_t2 got rdata=%h done=%b required deadbeef 1", rd, dn);
    end
    $display("lw addr=00000010 rdata=%h", rd);
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic dn;
    preload(11'd4, 32'h11223344);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h555555AB);
    @(negedge clk);
    req = 1'b0;
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b110100) begin
      errors++; $display("FAIL sb_t1 got %b required 110100", {DM_cs, DM_r, DM_w, busy, done, exc});
    end
    @(negedge clk);
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b101100 || dm_wdata !== 32'h11AB3344) begin
      errors++; $display("FAIL sb_t2 got flags=%b wdata=%h required 101100 11ab3344", {DM_cs, DM_r, DM_w, busy, done, exc}, dm_wdata);
    end
    @(negedge clk);
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b000010 || mem[4] !== 32'h11AB3344) begin
      errors++; $display("FAIL sb_t3 got flags=%b mem=%h required 000010 11ab3344", {DM_cs, DM_r, DM_w, busy, done, exc}, mem[4]);
    end
    $display("sb addr=00000012 data=ab word=%h", mem[4]);
    do_load(32'h12, 2'b00, 1'b1, rd, dn);
    checks++;
    if (rd !== 32'hFFFFFFAB || dn !== 1'b1) begin errors++; $display("FAIL lb_12 got %h done=%b required ffffffab", rd, dn); end
    do_load(32'h12, 2'b00, 1'b0, rd, dn);
    checks++;
    if (rd !== 32'h000000AB || dn !== 1'b1) begin errors++; $display("FAIL lbu_12 got %h done=%b required 000000ab", rd, dn); end
    do_load(32'h10, 2'b00, 1'b1, rd, dn);
    checks++;
    if (rd !== 32'h00000044) begin errors++; $display("FAIL lb_10 got %h required 00000044", rd); end
    do_load(32'h13, 2'b00, 1'b0, rd, dn);
    checks++;
    if (rd !== 32'h00000011) begin errors++; $display("FAIL lbu_13 got %h required 00000011", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic dn;
    preload(11'd5, 32'h0);
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (DM_w !== 1'b1 || dm_addr !== 11'd5 || dm_wdata !== 32'h80010000) begin
      errors++; $display("FAIL sh_t2 got w=%b addr=%h wdata=%h required 1 5 80010000", DM_w, dm_addr, dm_wdata);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem[5] !== 32'h80010000) begin
      errors++; $display("FAIL sh_t3 got done=%b mem=%h required 1 80010000", done, mem[5]);
    end
    $display("sh addr=00000016 data=8001 word=%h", mem[5]);
    do_load(32'h16, 2'b01, 1'b1, rd, dn);
    checks++;
    if (rd !== 32'hFFFF8001 || dn !== 1'b1) begin errors++; $display("FAIL lh_16 got %h done=%b required ffff8001", rd, dn); end
    do_load(32'h14, 2'b01, 1'b1, rd, dn);
    checks++;
    if (rd !== 32'h00000000) begin errors++; $display("FAIL lh_14 got %h required 00000000", rd); end
    do_load(32'h16, 2'b01, 1'b0, rd, dn);
    checks++;
    if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_16 got %h required 00008001", rd); end
  endtask

  task automatic test_exc;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        1:       drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF);
        default: drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      endcase
      @(negedge clk);
      req = 1'b0;
      checks++;
      if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b000001 || rdata !== 32'h00008001) begin
        errors++; $display("FAIL exc_%0d_t1 got flags=%b rdata=%h required 000001 00008001",
                           i, {DM_cs, DM_r, DM_w, busy, done, exc}, rdata);
      end
      @(negedge clk);
      checks++;
      if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b000000 || mem[4] !== 32'h11AB3344) begin
        errors++; $display("FAIL exc_%0d_t2 got flags=%b mem=%h required 000000 11ab3344",
                           i, {DM_cs, DM_r, DM_w, busy, done, exc}, mem[4]);
      end
      $display("exception case %0d addr=%h", i, addr);
    end
    // A legal request in the exc cycle is accepted straight away
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    req = 1'b0;
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b110100 || dm_addr !== 11'd4) begin
      errors++; $display("FAIL exc_then_lw got flags=%b addr=%h required 110100 4", {DM_cs, DM_r, DM_w, busy, done, exc}, dm_addr);
    end
    @(negedge clk);
    checks++;
    if (rdata !== 32'h11AB3344 || done !== 1'b1) begin
      errors++; $display("FAIL exc_then_lw_data got %h done=%b required 11ab3344 1", rdata, done);
    end
    $display("lw after exception rdata=%h", rdata);
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000077);
    @(negedge clk);
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b110100) begin
      errors++; $display("FAIL busy_t1 got %b required 110100", {DM_cs, DM_r, DM_w, busy, done, exc});
    end
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    @(negedge clk);
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b101100 || dm_addr !== 11'd4 || dm_wdata !== 32'h11AB3377) begin
      errors++; $display("FAIL busy_t2 got flags=%b addr=%h wdata=%h required 101100 4 11ab3377",
                         {DM_cs, DM_r, DM_w, busy, done, exc}, dm_addr, dm_wdata);
    end
    @(negedge clk);
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b000010) begin
      errors++; $display("FAIL busy_t3 got %b required 000010", {DM_cs, DM_r, DM_w, busy, done, exc});
    end
    @(negedge clk);
    req = 1'b0;
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b101100 || dm_addr !== 11'd8 || dm_wdata !== 32'h12345678) begin
      errors++; $display("FAIL busy_t4 got flags=%b addr=%h wdata=%h required 101100 8 12345678",
                         {DM_cs, DM_r, DM_w, busy, done, exc}, dm_addr, dm_wdata);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem[8] !== 32'h12345678 || mem[4] !== 32'h11AB3377) begin
      errors++; $display("FAIL busy_t5 got done=%b mem8=%h mem4=%h required 1 12345678 11ab3377", done, mem[8], mem[4]);
    end
    $display("sb held then sw accepted in done cycle mem8=%h", mem[8]);
  endtask

  task automatic test_reset_mid;
    preload(11'd6, 32'hCAFEF00D);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h18, 32'h00000099);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (DM_w !== 1'b1 || dm_wdata !== 32'hCAFEF099) begin
      errors++; $display("FAIL rmid_wr got w=%b wdata=%h required 1 cafef099", DM_w, dm_wdata);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({DM_cs, DM_r, DM_w, busy, done, exc} !== 6'b0 || rdata !== 32'h0 || dm_addr !== 11'h0 || dm_wdata !== 32'h0) begin
      errors++; $display("FAIL rmid_async got flags=%b rdata=%h addr=%h wdata=%h required all 0",
                         {DM_cs, DM_r, DM_w, busy, done, exc}, rdata, dm_addr, dm_wdata);
    end
    @(negedge clk);
    checks++;
    if (mem[6] !== 32'hCAFEF00D) begin errors++; $display("FAIL rmid_mem got %h required cafef00d", mem[6]); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_release got busy=%b done=%b required 0 0", busy, done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || mem[6] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rmid_nodone got done=%b mem=%h required 0 cafef00d", done, mem[6]);
    end
    $display("reset during rmw write: mem6=%h", mem[6]);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_exc();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store sequencer between the CPU memory stage and the word-organised data RAM. It converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses on the RAM port. Loads get lane extraction and sign/zero extension. Sub-word stores become a two-cycle read-modify-write, because the RAM only writes whole words. The unit stalls the pipeline through `busy` and flags misaligned or illegal accesses without touching memory.

## Interface
Parameters: none (RAM word index fixed at 11 bits; byte lanes little-endian).

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  1  access request, sampled only in IDLE
- `we`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `addr`  in  32  byte address; [12:2] selects word, [1:0] selects lane, [31:13] ignored
- `wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `rdata`  out  32  extended load result, registered
- `done`  out  1  one-cycle pulse: access complete
- `busy`  out  1  high whenever state ≠ IDLE
- `exc`  out  1  one-cycle pulse: misaligned or illegal-size request
- `DM_cs`, `DM_r`, `DM_w`  out  1 each  RAM chip select, read, write
- `dm_addr`  out  11  RAM word index
- `dm_wdata`  out  32  RAM write word
- `dm_rdata`  in  32  RAM read word; combinational when DM_cs&DM_r, may be Z otherwise

## Operation
- States: IDLE, LD, ST, RMW_RD, RMW_WR.
- IDLE with `req`=1:
  - Latch `we`, `size`, `sign_ext`, `addr`, `wdata`.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size=11: stay IDLE, pulse `exc`, no RAM strobes, no `done`.
  - Load → LD.
  - Word store → ST.
  - Byte/half store → RMW_RD.
- `req` while busy is ignored; the CPU holds the request until `busy` is low.
- LD:
  - DM_cs=DM_r=1.
  - Select lane `dm_rdata[8*addr[1:0] +: 8]` (byte) or `[16*addr[1] +: 16]` (half).
  - Extend per `sign_ext`; word is passed unchanged.
  - Register into `rdata` and go to IDLE.
- ST: DM_cs=DM_w=1, `dm_wdata`=latched wdata → IDLE.
- RMW_RD: DM_cs=DM_r=1; capture `dm_rdata` into the merge register → RMW_WR.
- RMW_WR:
  - DM_cs=DM_w=1.
  - `dm_wdata` = captured word with the target lane replaced by wdata[7:0] or wdata[15:0]; all other lanes unchanged.
  - → IDLE.
- `done` is registered and pulses in the cycle after the final RAM cycle (LD, ST or RMW_WR).
- `rdata` holds its value until the next load completes; stores and exceptions do not change it.
- `dm_rdata` is sampled only while DM_r=1.

## Timing
- Reset (asynchronous, immediate): state=IDLE; `rdata`=0, `done`=0, `busy`=0, `exc`=0, `DM_cs`=`DM_r`=`DM_w`=0, `dm_addr`=0, `dm_wdata`=0.
- Request accepted in cycle T (IDLE, req=1). RAM outputs are driven from state and latched fields, so they are stable for the whole cycle.
- Load: LD in T+1; `rdata` valid and `done`=1 in T+2; `busy` high in T+1 only.
- Word store: ST in T+1, RAM written at end of T+1; `done` in T+2.
- Sub-word store: RMW_RD in T+1, RMW_WR in T+2; `done` in T+3; `busy` high in T+1..T+2.
- Exception: `exc`=1 in T+1; `busy` never rises; next request accepted in T+1.
- Back-to-back: the unit is in IDLE during the `done` cycle, so a new `req` there is accepted (throughput 2 cycles per load or word store, 3 per sub-word store).
- Reset mid-operation:
  - Strobes drop immediately.
  - If reset is asserted during ST or RMW_WR before the rising edge, no write occurs.
  - No `done` is produced for an aborted access.
- DM_r and DM_w are never high in the same cycle. DM_cs is high exactly when one of them is.

## Test plan
- Reset: assert `rst_n`=0 mid-RMW_WR → all outputs 0 immediately; RAM word unchanged; after release `busy`=0.
- Word path: sw 0xDEADBEEF to addr 0x0000_0010, then lw from 0x10 → DM_w pulse at T+1 with dm_addr=4; `rdata`=0xDEADBEEF with `done` at T+2 of the load.
- Byte store and loads: memory word 4 preloaded with 0x11223344; sb 0xAB to 0x12 → word becomes 0x11AB3344 (DM_r at T+1, DM_w at T+2, `done` at T+3). lb from 0x12 → `rdata`=0xFFFFFFAB; lbu from 0x12 → 0x000000AB.
- Halfword: sh 0x8001 to 0x16 on word 5 = 0 → word = 0x80010000. lh from 0x16 → 0xFFFF8001; lhu → 0x00008001.
- Exceptions: lw at 0x13, sh at 0x11, size=11 at 0x10 → `exc` pulse each time; no DM strobes, no `done`, `rdata` unchanged.
- Busy handling: hold `req` with a new store during RMW → ignored until IDLE; request issued in the `done` cycle is accepted, giving no idle gap.
